// File: rtl/v_pkg.sv
// Shared definitions for the vector load/store sequencer.
//   lsu_state_t          : controller FSM states
//   VLE8 .. VSSE32       : v_lsu_op encodings (1-6 loads, 7-12 stores)
//   is_lsu_load/store/legal : op classification helpers
//   DATAMEM_BITS/WIDTH   : data memory geometry, kept in step with constants.vh
package v_pkg;

  localparam int unsigned DATAMEM_BITS  = 10;
  localparam int unsigned DATAMEM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    CMPL = 2'd3
  } lsu_state_t;

  localparam logic [3:0] VLE8   = 4'd1;
  localparam logic [3:0] VLE16  = 4'd2;
  localparam logic [3:0] VLE32  = 4'd3;
  localparam logic [3:0] VLSE8  = 4'd4;
  localparam logic [3:0] VLSE16 = 4'd5;
  localparam logic [3:0] VLSE32 = 4'd6;
  localparam logic [3:0] VSE8   = 4'd7;
  localparam logic [3:0] VSE16  = 4'd8;
  localparam logic [3:0] VSE32  = 4'd9;
  localparam logic [3:0] VSSE8  = 4'd10;
  localparam logic [3:0] VSSE16 = 4'd11;
  localparam logic [3:0] VSSE32 = 4'd12;

  function automatic logic is_lsu_load(input logic [3:0] op);
    return (op >= VLE8) && (op <= VLSE32);
  endfunction

  function automatic logic is_lsu_store(input logic [3:0] op);
    return (op >= VSE8) && (op <= VSSE32);
  endfunction

  function automatic logic is_lsu_legal(input logic [3:0] op);
    return is_lsu_load(op) || is_lsu_store(op);
  endfunction

endpackage

// File: rtl/v_lsu_bankmux.sv
// Routes the load/store unit bank ports onto the four data memory banks.
//   is_store   : a store op is latched (selects store unit addresses)
//   run        : controller is in RUN (gates the write enables)
//   su_addr    : store unit bank addresses, bank0 in LSBs
//   su_wdata   : store unit bank write data, bank0 in LSBs
//   lu_addr    : load unit bank addresses, bank0 in LSBs
//   bank_addr  : addresses to the banks
//   bank_wdata : write data to the banks
//   bank_we    : per-bank write enable
module v_lsu_bankmux
  import v_pkg::*;
(
  input  logic                       is_store,
  input  logic                       run,
  input  logic [4*DATAMEM_BITS-1:0]  su_addr,
  input  logic [4*DATAMEM_WIDTH-1:0] su_wdata,
  input  logic [4*DATAMEM_BITS-1:0]  lu_addr,
  output logic [4*DATAMEM_BITS-1:0]  bank_addr,
  output logic [4*DATAMEM_WIDTH-1:0] bank_wdata,
  output logic [3:0]                 bank_we
);

  always_comb begin
    bank_addr  = is_store ? su_addr : lu_addr;
    // Write data only matters while bank_we is high, so it is never muxed.
    bank_wdata = su_wdata;
    bank_we    = (is_store && run) ? 4'b1111 : 4'b0000;
  end

endmodule

// File: rtl/v_lsu_ctrl.sv
// Sequencer for the vector load/store units. Accepts one vector memory op at a
// time, latches its configuration, takes the selected unit through a held-reset
// ARM cycle into RUN, waits for its done (or a timeout) and reports completion.
//   clk, nrst              : clock, synchronous active-low reset
//   req_*                  : request handshake and configuration from decode
//   u_*                    : latched configuration to both units
//   lu_nrst, su_nrst       : unit resets, released only in RUN
//   lu_done, su_done       : unit completion
//   su_addr, su_wdata      : store unit bank ports
//   lu_addr                : load unit bank addresses
//   bank_addr/wdata/we     : data memory bank ports
//   cmpl_valid/op/err      : one-cycle completion report
module v_lsu_ctrl
  import v_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_op,
  input  logic [2:0]                 req_lmul,
  input  logic [2:0]                 req_vsew,
  input  logic [4:0]                 req_stride,
  input  logic [DATAMEM_BITS-1:0]    req_addr,
  output logic [3:0]                 u_op,
  output logic [2:0]                 u_lmul,
  output logic [2:0]                 u_vsew,
  output logic [4:0]                 u_stride,
  output logic [DATAMEM_BITS-1:0]    u_addr,
  output logic                       lu_nrst,
  output logic                       su_nrst,
  input  logic                       lu_done,
  input  logic                       su_done,
  input  logic [4*DATAMEM_BITS-1:0]  su_addr,
  input  logic [4*DATAMEM_WIDTH-1:0] su_wdata,
  input  logic [4*DATAMEM_BITS-1:0]  lu_addr,
  output logic [4*DATAMEM_BITS-1:0]  bank_addr,
  output logic [4*DATAMEM_WIDTH-1:0] bank_wdata,
  output logic [3:0]                 bank_we,
  output logic                       cmpl_valid,
  output logic [3:0]                 cmpl_op,
  output logic                       cmpl_err
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  lsu_state_t             state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [2:0]             lmul_q, lmul_d;
  logic [2:0]             vsew_q, vsew_d;
  logic [4:0]             stride_q, stride_d;
  logic [DATAMEM_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic store_latched;
  logic unit_done;

  assign store_latched = is_lsu_store(op_q);
  // Only the selected unit's done counts; the other one is held in reset anyway.
  assign unit_done     = store_latched ? su_done : lu_done;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      lmul_q   <= '0;
      vsew_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lmul_q   <= lmul_d;
      vsew_q   <= vsew_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lmul_d   = lmul_q;
    vsew_d   = vsew_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          lmul_d   = req_lmul;
          vsew_d   = req_vsew;
          stride_d = req_stride;
          addr_d   = req_addr;
          if (is_lsu_legal(req_op)) begin
            err_d   = 1'b0;
            state_d = ARM;
          end else begin
            err_d   = 1'b1;
            state_d = CMPL;
          end
        end
      end
      ARM: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // done takes priority over a timeout landing in the same cycle.
        if (unit_done) begin
          err_d   = 1'b0;
          state_d = CMPL;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = CMPL;
        end
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CMPL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = 1'b0;
    lu_nrst    = 1'b0;
    su_nrst    = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_op    = '0;
    cmpl_err   = 1'b0;

    unique case (state_q)
      IDLE: req_ready = 1'b1;
      ARM:  ;
      RUN: begin
        lu_nrst = !store_latched;
        su_nrst = store_latched;
      end
      CMPL: begin
        cmpl_valid = 1'b1;
        cmpl_op    = op_q;
        cmpl_err   = err_q;
      end
      default: ;
    endcase
  end

  assign u_op     = op_q;
  assign u_lmul   = lmul_q;
  assign u_vsew   = vsew_q;
  assign u_stride = stride_q;
  assign u_addr   = addr_q;

  v_lsu_bankmux u_bankmux (
    .is_store   (store_latched),
    .run        (state_q == RUN),
    .su_addr    (su_addr),
    .su_wdata   (su_wdata),
    .lu_addr    (lu_addr),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we)
  );

endmodule

// File: tb/tb_v_lsu_ctrl.sv
// Bench for v_lsu_ctrl: directed requests with a completion scoreboard.
module tb_v_lsu_ctrl;
  import v_pkg::*;

  logic                       clk = 1'b0;
  logic                       nrst;
  logic                       req_valid;
  logic                       req_ready;
  logic [3:0]                 req_op;
  logic [2:0]                 req_lmul;
  logic [2:0]                 req_vsew;
  logic [4:0]                 req_stride;
  logic [DATAMEM_BITS-1:0]    req_addr;
  logic [3:0]                 u_op;
  logic [2:0]                 u_lmul;
  logic [2:0]                 u_vsew;
  logic [4:0]                 u_stride;
  logic [DATAMEM_BITS-1:0]    u_addr;
  logic                       lu_nrst;
  logic                       su_nrst;
  logic                       lu_done;
  logic                       su_done;
  logic [4*DATAMEM_BITS-1:0]  su_addr;
  logic [4*DATAMEM_WIDTH-1:0] su_wdata;
  logic [4*DATAMEM_BITS-1:0]  lu_addr;
  logic [4*DATAMEM_BITS-1:0]  bank_addr;
  logic [4*DATAMEM_WIDTH-1:0] bank_wdata;
  logic [3:0]                 bank_we;
  logic                       cmpl_valid;
  logic [3:0]                 cmpl_op;
  logic                       cmpl_err;

  typedef struct packed {
    logic [3:0] op;
    logic       err;
  } cmpl_t;

  cmpl_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  v_lsu_ctrl #(
    .TIMEOUT (8),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_lmul   (req_lmul),
    .req_vsew   (req_vsew),
    .req_stride (req_stride),
    .req_addr   (req_addr),
    .u_op       (u_op),
    .u_lmul     (u_lmul),
    .u_vsew     (u_vsew),
    .u_stride   (u_stride),
    .u_addr     (u_addr),
    .lu_nrst    (lu_nrst),
    .su_nrst    (su_nrst),
    .lu_done    (lu_done),
    .su_done    (su_done),
    .su_addr    (su_addr),
    .su_wdata   (su_wdata),
    .lu_addr    (lu_addr),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we),
    .cmpl_valid (cmpl_valid),
    .cmpl_op    (cmpl_op),
    .cmpl_err   (cmpl_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request while IDLE; returns in the cycle after the accept edge (ARM).
  task automatic issue(input logic [3:0] op, input logic [2:0] lmul, input logic [2:0] vsew,
                       input logic [DATAMEM_BITS-1:0] addr);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait: req_ready got 0, required 1 within 50 cycles");
    end
    req_valid  = 1'b1;
    req_op     = op;
    req_lmul   = lmul;
    req_vsew   = vsew;
    req_stride = 5'd4;
    req_addr   = addr;
    step();
    req_valid  = 1'b0;
  endtask

  // Completion monitor: every cmpl_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    cmpl_t e;
    if (cmpl_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmpl_unexpected: got op %0d err %0d, required no completion",
                 cmpl_op, cmpl_err);
      end else begin
        e = exp_q.pop_front();
        check("cmpl_op", 128'(cmpl_op), 128'(e.op));
        check("cmpl_err", 128'(cmpl_err), 128'(e.err));
      end
    end
  end

  initial begin
    int cnt;
    int guard;
    nrst       = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_lmul   = '0;
    req_vsew   = '0;
    req_stride = '0;
    req_addr   = '0;
    lu_done    = 1'b0;
    su_done    = 1'b0;
    su_addr    = {10'h104, 10'h103, 10'h102, 10'h101};
    lu_addr    = {10'h204, 10'h203, 10'h202, 10'h201};
    su_wdata   = 128'hdddd_dddd_cccc_cccc_bbbb_bbbb_aaaa_aaaa;
    step();
    step();

    // Reset state
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_lu_nrst", 128'(lu_nrst), 128'(0));
    check("rst_su_nrst", 128'(su_nrst), 128'(0));
    check("rst_bank_we", 128'(bank_we), 128'(0));
    check("rst_cmpl", 128'({cmpl_valid, cmpl_err, cmpl_op}), 128'(0));
    check("rst_u_cfg", 128'({u_op, u_lmul, u_vsew, u_stride, u_addr}), 128'(0));
    nrst = 1'b1;
    step();

    // vse32: store done on RUN cycle 3
    exp_q.push_back('{op: 4'd9, err: 1'b0});
    issue(4'd9, 3'd0, 3'b010, 10'd0);
    check("st_arm_su_nrst", 128'(su_nrst), 128'(0));
    check("st_arm_lu_nrst", 128'(lu_nrst), 128'(0));
    check("st_arm_we", 128'(bank_we), 128'(0));
    check("st_arm_ready", 128'(req_ready), 128'(0));
    check("st_u_cfg", 128'({u_op, u_lmul, u_vsew, u_stride}), 128'({4'd9, 3'd0, 3'd2, 5'd4}));
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 3) su_done = 1'b1;
      check("st_run_su_nrst", 128'(su_nrst), 128'(1));
      check("st_run_lu_nrst", 128'(lu_nrst), 128'(0));
      check("st_run_we", 128'(bank_we), 128'(4'hf));
    end
    check("st_bank_addr", 128'(bank_addr), 128'(su_addr));
    check("st_bank_wdata", bank_wdata, su_wdata);
    step();
    su_done = 1'b0;
    check("st_cmpl_valid", 128'(cmpl_valid), 128'(1));
    check("st_cmpl_we", 128'(bank_we), 128'(0));
    check("st_cmpl_su_nrst", 128'(su_nrst), 128'(0));
    check("st_cmpl_ready", 128'(req_ready), 128'(0));
    step();
    check("st_ready_back", 128'(req_ready), 128'(1));

    // vle16 with a stray su_done during RUN
    exp_q.push_back('{op: 4'd2, err: 1'b0});
    issue(4'd2, 3'd1, 3'b001, 10'h3c);
    check("ld_arm_lu_nrst", 128'(lu_nrst), 128'(0));
    step();
    check("ld_run_lu_nrst", 128'(lu_nrst), 128'(1));
    check("ld_run_su_nrst", 128'(su_nrst), 128'(0));
    check("ld_run_we", 128'(bank_we), 128'(0));
    check("ld_bank_addr", 128'(bank_addr), 128'(lu_addr));
    su_done = 1'b1;
    step();
    su_done = 1'b0;
    check("ld_stray_no_cmpl", 128'(cmpl_valid), 128'(0));
    check("ld_stray_still_run", 128'(lu_nrst), 128'(1));
    check("ld_stray_we", 128'(bank_we), 128'(0));
    lu_done = 1'b1;
    step();
    lu_done = 1'b0;
    check("ld_cmpl_valid", 128'(cmpl_valid), 128'(1));
    step();

    // Illegal ops complete one cycle after accept without touching units
    exp_q.push_back('{op: 4'd0, err: 1'b1});
    issue(4'd0, 3'd0, 3'd0, 10'h11);
    check("ill0_cmpl_valid", 128'(cmpl_valid), 128'(1));
    check("ill0_unit_nrst", 128'({lu_nrst, su_nrst}), 128'(0));
    step();
    exp_q.push_back('{op: 4'd13, err: 1'b1});
    issue(4'd13, 3'd0, 3'd0, 10'h12);
    check("ill13_cmpl_valid", 128'(cmpl_valid), 128'(1));
    check("ill13_unit_nrst", 128'({lu_nrst, su_nrst}), 128'(0));
    step();

    // Timeout: vle8 with no done runs exactly 8 RUN cycles
    exp_q.push_back('{op: 4'd1, err: 1'b1});
    issue(4'd1, 3'd0, 3'd0, 10'h20);
    step();
    cnt   = 0;
    guard = 0;
    while (!cmpl_valid && guard < 20) begin
      if (lu_nrst) cnt++;
      step();
      guard++;
    end
    check("to_run_cycles", 128'(cnt), 128'(8));
    step();

    // done on the timeout cycle wins
    exp_q.push_back('{op: 4'd7, err: 1'b0});
    issue(4'd7, 3'd0, 3'd0, 10'h30);
    step();
    for (int k = 0; k < 7; k++) step();
    check("to_edge_run8", 128'(su_nrst), 128'(1));
    su_done = 1'b1;
    step();
    su_done = 1'b0;
    check("to_edge_cmpl", 128'(cmpl_valid), 128'(1));
    step();

    // Reset in the middle of a store RUN drops the op
    issue(4'd10, 3'd0, 3'd0, 10'h40);
    step();
    step();
    check("rr_we_before", 128'(bank_we), 128'(4'hf));
    nrst = 1'b0;
    step();
    check("rr_we", 128'(bank_we), 128'(0));
    check("rr_su_nrst", 128'(su_nrst), 128'(0));
    check("rr_ready", 128'(req_ready), 128'(1));
    check("rr_cmpl", 128'(cmpl_valid), 128'(0));
    check("rr_u_op", 128'(u_op), 128'(0));
    nrst = 1'b1;
    exp_q.push_back('{op: 4'd3, err: 1'b0});
    issue(4'd3, 3'd0, 3'd0, 10'h41);
    check("rr_accept_u_op", 128'(u_op), 128'(3));
    step();
    lu_done = 1'b1;
    step();
    lu_done = 1'b0;
    step();

    // req_valid held high: accepted only in IDLE, config stable to CMPL
    exp_q.push_back('{op: 4'd8, err: 1'b0});
    exp_q.push_back('{op: 4'd4, err: 1'b0});
    req_valid  = 1'b1;
    req_op     = 4'd8;
    req_lmul   = 3'd2;
    req_vsew   = 3'd1;
    req_stride = 5'd7;
    req_addr   = 10'h155;
    step();
    req_op   = 4'd4;
    req_addr = 10'h2aa;
    check("hv_arm_u", 128'({u_op, u_addr}), 128'({4'd8, 10'h155}));
    for (int k = 1; k <= 2; k++) begin
      step();
      if (k == 2) su_done = 1'b1;
      check("hv_run_u", 128'({u_op, u_addr}), 128'({4'd8, 10'h155}));
    end
    step();
    su_done = 1'b0;
    check("hv_cmpl_u", 128'({u_op, u_addr}), 128'({4'd8, 10'h155}));
    step();
    check("hv_idle_ready", 128'(req_ready), 128'(1));
    check("hv_idle_u", 128'(u_op), 128'(8));
    step();
    req_valid = 1'b0;
    check("hv_next_u", 128'({u_op, u_addr}), 128'({4'd4, 10'h2aa}));
    step();
    lu_done = 1'b1;
    step();
    lu_done = 1'b0;
    step();
    step();

    check("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_lsu_ctrl.md
# v_lsu_ctrl

Sequencer for the vector load/store units. It accepts one vector memory instruction at a time from vector decode and latches its configuration. It pulses the selected unit through a clean start (held reset, then run) and waits for that unit's `done`. It routes the unit's four bank ports to the data memory and returns a one-cycle completion with an error flag for illegal ops and timeouts.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum RUN cycles before abort; range 2..255.
- `CNT_W`, 8: timeout counter width.

Ports. All clocking is on the single clock `clk`; reset is synchronous and active-low on `nrst`.
- `clk`  in  1  clock
- `nrst`  in  1  synchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept
- `req_op`  in  4  v_lsu_op: 1–6 loads (vle8/16/32, vlse8/16/32), 7–12 stores (vse8/16/32, vsse8/16/32)
- `req_lmul`, `req_vsew`  in  3 each  vtype fields
- `req_stride`  in  5  element stride
- `req_addr`  in  `DATAMEM_BITS`  base address
- `u_op`, `u_lmul`, `u_vsew`, `u_stride`, `u_addr`  out  as above  latched config to both units
- `lu_nrst`, `su_nrst`  out  1 each  registered reset to load/store unit
- `lu_done`, `su_done`  in  1 each  unit completion
- `su_addr`  in  4×`DATAMEM_BITS`  store unit `data_addr0..3`, flattened, bank0 in LSBs
- `su_wdata`  in  4×`DATAMEM_WIDTH`  store unit `data_out0..3`, same packing
- `lu_addr`  in  4×`DATAMEM_BITS`  load unit bank addresses
- `bank_addr`  out  4×`DATAMEM_BITS`  to data memory banks
- `bank_wdata`  out  4×`DATAMEM_WIDTH`  to banks
- `bank_we`  out  4  per-bank write enable
- `cmpl_valid`  out  1  one-cycle completion pulse
- `cmpl_op`  out  4  op that completed
- `cmpl_err`  out  1  1 = illegal op or timeout

## Operation
- States: IDLE, ARM, RUN, CMPL.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch all `req_*` into `u_*`.
  - Legal op (1–12) → ARM.
  - Illegal op (0, 13–15) → CMPL with the error flag set; no unit is touched.
- ARM, one cycle:
  - The selected unit's `*_nrst`=0 to clear its internal element counters.
  - The other unit's reset stays 0.
  - Timeout counter is cleared → RUN.
- RUN:
  - The selected unit's `*_nrst`=1.
  - The counter increments each cycle.
  - The selected unit's `done`=1 → CMPL, `err`=0.
  - Counter reaching `TIMEOUT`-1 without `done` → CMPL, `err`=1.
  - If `done` arrives in the same cycle as the timeout, `done` wins and `err`=0.
  - The non-selected unit's `done` is ignored.
- CMPL:
  - `cmpl_valid`=1; `cmpl_op`=`u_op`; `cmpl_err` holds the latched flag.
  - Both unit resets are 0 → IDLE.
- Bank routing:
  - `bank_addr` = `su_addr` when a store is latched, `lu_addr` otherwise.
  - `bank_wdata` = `su_wdata`.
  - `bank_we` = 4'b1111 only in RUN with a store latched (including the `done` cycle); 0 otherwise.
- Unit resets are 0 in every state except RUN. Units never run unsupervised.
- `u_*` stay stable from ARM through CMPL and hold their value in IDLE until the next accept.

## Timing
- Reset values: state IDLE, `req_ready`=1, `lu_nrst`=`su_nrst`=0, `bank_we`=0, `cmpl_valid`=0, `cmpl_err`=0, `cmpl_op`=0, `u_*`=0, counter=0.
- Request accepted at edge N.
- ARM occupies cycle N+1.
- RUN starts at N+2.
- Unit `done` sampled at edge M gives `cmpl_valid` in cycle M+1 and `req_ready` in cycle M+2.
- Illegal op accepted at N gives `cmpl_valid` at N+1.
- Throughput: one op per (RUN length + 3) cycles; no back-to-back overlap.
- `req_ready` is a function of state only; it has no combinational path from `req_valid`.
- `nrst` low in any state returns to IDLE at the next edge:
  - Outputs take their reset values; any in-flight op is dropped without completion.
- Timeout counter is `CNT_W` bits, saturating; it never wraps.

## Structure
- `v_pkg` holds:
  - `lsu_state_t` enum (IDLE/ARM/RUN/CMPL);
  - v_lsu_op localparams (`VLE8`=1 … `VSSE32`=12);
  - functions `is_lsu_load(op)` (1–6), `is_lsu_store(op)` (7–12) and `is_lsu_legal(op)`.
- `DATAMEM_BITS` and `DATAMEM_WIDTH` come from `constants.vh`.
- One sub-module, `v_lsu_bankmux`: combinational routing of the unit bank ports to `bank_addr`, `bank_wdata` and `bank_we`, driven by `is_store` and `run`.

## Test plan
- vse32 accepted: op=9, lmul=0, vsew=010, addr=0, `su_done` at RUN cycle 3. Required:
  - `su_nrst` 0 for one cycle then 1;
  - `bank_we`=1111 for exactly 3 cycles;
  - `bank_addr`=`su_addr`;
  - `cmpl_valid`=1 with op=9, err=0;
  - `req_ready` returns 2 cycles after `done`.
- vle16, op=2: `lu_nrst` sequences and `bank_we` stays 0 throughout. A stray `su_done`=1 during RUN is ignored; completion happens only on `lu_done`.
- Illegal op=0, then op=13: each completes 1 cycle after accept with err=1; `lu_nrst`/`su_nrst` stay 0.
- `TIMEOUT`=8 with no `done`: `cmpl_err`=1 after 8 RUN cycles. The case where `done` and timeout land in the same cycle yields err=0.
- `nrst` pulled low mid-RUN of a store: next edge gives IDLE, `bank_we`=0, `su_nrst`=0, no `cmpl_valid`. A new request is accepted on the first cycle after release.
- `req_valid` held high continuously: ops are accepted only in IDLE, and `u_*` do not change between ARM and CMPL.
